// File: rtl/cache_refill_ctrl_pkg.sv
// Shared widths and types for the cache miss refill sequencer.
// Holds the design_params values, the pipe2 entry layout, the
// controller state encoding and the memory request bundle.
package cache_refill_ctrl_pkg;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int NUM_WAYS        = 4;
    localparam int REQ_ID          = 3;
    localparam int OFFSET_WIDTH    = 3;
    localparam int TAG_WIDTH       = 29;
    localparam int WORDS_PER_BLOCK = 8;

    // Controller sequencing states
    typedef enum logic [2:0] {
        CTRL_IDLE       = 3'd0,
        CTRL_WB_RD      = 3'd1,
        CTRL_WB_REQ     = 3'd2,
        CTRL_FETCH_REQ  = 3'd3,
        CTRL_FETCH_WAIT = 3'd4,
        CTRL_DONE       = 3'd5
    } ctrl_state_t;

    // Entry handed over by the pipe2 decision stage
    typedef struct packed {
        logic [REQ_ID-1:0]    req_id;
        logic [TAG_WIDTH-1:0] tag;
        logic [NUM_WAYS-1:0]  victim_way;
        logic                 do_fetch;
        logic                 do_writeback;
    } pipe2_t;

    // One word-sized memory request
    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } mem_req_t;

    // Memory is word addressed: the block tag followed by the word index
    function automatic logic [ADDRESS_WIDTH-1:0] make_word_addr(
        input logic [TAG_WIDTH-1:0]    tag,
        input logic [OFFSET_WIDTH-1:0] word
    );
        return {tag, word};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Word-wide memory bus between the refill controller and memory.
// The controller drives requests (master); memory answers (slave).
interface cache_refill_ctrl_if;
    import cache_refill_ctrl_pkg::*;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_we;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0]    mem_req_wdata;
    logic                     mem_rsp_valid;
    logic [DATA_WIDTH-1:0]    mem_rsp_data;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_rsp_valid,
        output mem_rsp_data
    );

endinterface

// File: rtl/cache_refill_ctrl_beat.sv
// Beat counter for the refill sequencer: walks the word index of the
// block being written back or fetched and flags the final word.
module cache_beat_counter
    import cache_refill_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    incr,
    output logic [OFFSET_WIDTH-1:0] beat,
    output logic                    last_beat
);

    // Clear wins so the last-beat transition always lands back on word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (incr) begin
            beat <= beat + 1'b1;
        end
    end

    assign last_beat = (beat == OFFSET_WIDTH'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling sequencer behind the pipe2 decision stage. Takes one
// entry, optionally streams the dirty victim block out to memory, then
// optionally fetches the missing block into the data array, stalling
// the pipeline throughout and pulsing done with the entry's req_id.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  pipe2_t                   miss_req,
    output logic                     stall,
    input  logic [TAG_WIDTH-1:0]     victim_tag,
    output logic                     victim_rd_en,
    output logic [NUM_WAYS-1:0]      victim_rd_way,
    output logic [OFFSET_WIDTH-1:0]  victim_rd_word,
    input  logic [DATA_WIDTH-1:0]    victim_rd_data,
    cache_refill_ctrl_if.master      mem,
    output logic                     refill_we,
    output logic [NUM_WAYS-1:0]      refill_way,
    output logic [OFFSET_WIDTH-1:0]  refill_word,
    output logic [DATA_WIDTH-1:0]    refill_data,
    output logic                     done_valid,
    output logic [REQ_ID-1:0]        done_req_id
);

    localparam logic [2:0] S_IDLE       = CTRL_IDLE;
    localparam logic [2:0] S_WB_RD      = CTRL_WB_RD;
    localparam logic [2:0] S_WB_REQ     = CTRL_WB_REQ;
    localparam logic [2:0] S_FETCH_REQ  = CTRL_FETCH_REQ;
    localparam logic [2:0] S_FETCH_WAIT = CTRL_FETCH_WAIT;
    localparam logic [2:0] S_DONE       = CTRL_DONE;

    logic [2:0]              state_q;
    logic [2:0]              state_d;
    logic                    accept;

    logic [REQ_ID-1:0]       req_id_q;
    logic [TAG_WIDTH-1:0]    fetch_tag_q;
    logic [NUM_WAYS-1:0]     victim_way_q;
    logic                    do_fetch_q;
    logic [TAG_WIDTH-1:0]    victim_tag_q;

    logic                    wb_data_fresh_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   wdata_sel;

    logic [OFFSET_WIDTH-1:0] beat;
    logic                    last_beat;
    logic                    beat_clr;
    logic                    beat_inc;

    logic                    req_valid_c;
    mem_req_t                req_c;

    assign accept = miss_valid && miss_ready;

    cache_beat_counter u_beat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (beat_clr),
        .incr      (beat_inc),
        .beat      (beat),
        .last_beat (last_beat)
    );

    // Next-state and beat-counter control for the refill sequence
    always_comb begin
        state_d  = state_q;
        beat_clr = 1'b0;
        beat_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    beat_clr = 1'b1;
                    if (miss_req.do_writeback) begin
                        state_d = S_WB_RD;
                    end else if (miss_req.do_fetch) begin
                        state_d = S_FETCH_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WB_RD: begin
                state_d = S_WB_REQ;
            end
            S_WB_REQ: begin
                if (mem.mem_req_ready) begin
                    if (last_beat) begin
                        beat_clr = 1'b1;
                        state_d  = do_fetch_q ? S_FETCH_REQ : S_DONE;
                    end else begin
                        beat_inc = 1'b1;
                        state_d  = S_WB_RD;
                    end
                end
            end
            S_FETCH_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    if (last_beat) begin
                        beat_clr = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        beat_inc = 1'b1;
                        state_d  = S_FETCH_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any sequence in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the entry and its victim tag when the miss is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_id_q     <= '0;
            fetch_tag_q  <= '0;
            victim_way_q <= '0;
            do_fetch_q   <= 1'b0;
            victim_tag_q <= '0;
        end else if (accept) begin
            req_id_q     <= miss_req.req_id;
            fetch_tag_q  <= miss_req.tag;
            victim_way_q <= miss_req.victim_way;
            do_fetch_q   <= miss_req.do_fetch;
            victim_tag_q <= victim_tag;
        end
    end

    // Array data shows up the cycle after the read; keep a copy so the
    // write request stays stable while memory holds off ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_fresh_q <= 1'b0;
            wdata_q         <= '0;
        end else begin
            wb_data_fresh_q <= (state_q == S_WB_RD);
            if (wb_data_fresh_q) begin
                wdata_q <= victim_rd_data;
            end
        end
    end

    assign wdata_sel = wb_data_fresh_q ? victim_rd_data : wdata_q;

    // Build the memory request for the current beat; idle bus reads as zero
    always_comb begin
        req_valid_c = 1'b0;
        req_c       = '0;
        case (state_q)
            S_WB_REQ: begin
                req_valid_c = 1'b1;
                req_c.we    = 1'b1;
                req_c.addr  = make_word_addr(victim_tag_q, beat);
                req_c.wdata = wdata_sel;
            end
            S_FETCH_REQ: begin
                req_valid_c = 1'b1;
                req_c.we    = 1'b0;
                req_c.addr  = make_word_addr(fetch_tag_q, beat);
            end
            default: begin
                req_valid_c = 1'b0;
            end
        endcase
    end

    assign mem.mem_req_valid = req_valid_c;
    assign mem.mem_req_we    = req_c.we;
    assign mem.mem_req_addr  = req_c.addr;
    assign mem.mem_req_wdata = req_c.wdata;

    assign miss_ready = (state_q == S_IDLE);
    assign stall      = !miss_ready;

    assign victim_rd_en   = (state_q == S_WB_RD);
    assign victim_rd_way  = victim_rd_en ? victim_way_q : '0;
    assign victim_rd_word = victim_rd_en ? beat : '0;

    assign refill_we   = (state_q == S_FETCH_WAIT) && mem.mem_rsp_valid;
    assign refill_way  = refill_we ? victim_way_q : '0;
    assign refill_word = refill_we ? beat : '0;
    assign refill_data = refill_we ? mem.mem_rsp_data : '0;

    assign done_valid  = (state_q == S_DONE);
    assign done_req_id = done_valid ? req_id_q : '0;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling sequencer placed after the pipe2 decision stage of the cache pipeline.
- Accepts one pipe2_t entry flagged do_fetch and/or do_writeback.
- If do_writeback, streams the dirty victim block out to memory word by word. If do_fetch, then fetches the missing block and writes it into the data array.
- Holds the pipeline stalled until the sequence completes, then pulses done with the originating req_id.

Parameters:
- All widths come from design_params: ADDRESS_WIDTH 32, DATA_WIDTH 32, NUM_WAYS 4, REQ_ID 3, OFFSET_WIDTH 3, TAG_WIDTH 29, WORDS_PER_BLOCK 8.
- No module-local parameters.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
miss_valid  in  1  pipe2 entry needs service
miss_ready  out  1  controller idle, can accept
miss_req  in  $bits(pipe2_t)  pipe2_t entry
stall  out  1  freeze upstream pipeline
victim_tag  in  TAG_WIDTH  tag of victim line (valid with miss_valid)
victim_rd_en  out  1  read victim data array word
victim_rd_way  out  NUM_WAYS  one-hot victim way
victim_rd_word  out  OFFSET_WIDTH  word index
victim_rd_data  in  DATA_WIDTH  array data, 1-cycle latency
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts
mem_req_we  out  1  1=write, 0=read
mem_req_addr  out  ADDRESS_WIDTH  word address {tag, word}
mem_req_wdata  out  DATA_WIDTH  write data
mem_rsp_valid  in  1  read data return
mem_rsp_data  in  DATA_WIDTH  read data
refill_we  out  1  write data array
refill_way  out  NUM_WAYS  one-hot target way (= victim)
refill_word  out  OFFSET_WIDTH  word index
refill_data  out  DATA_WIDTH  fill data
done_valid  out  1  one-cycle completion pulse
done_req_id  out  REQ_ID  req_id of completed entry

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, beat counter 0, all outputs 0 except miss_ready=1.
- Reset mid-operation: abandons the sequence immediately; no done pulse; partial memory writes are not undone.

Accept:
- An entry is accepted on miss_valid && miss_ready.
- On accept, latch miss_req, victim_tag and beat=0.
- miss_ready=1 only in IDLE. stall=1 in every state other than IDLE.

States:
- IDLE: on accept, go to WB_RD if do_writeback; else FETCH_REQ if do_fetch; else DONE.
- WB_RD:
  - victim_rd_en=1, word=beat, way=victim.
  - Next cycle capture victim_rd_data into a wdata register; go to WB_REQ.
- WB_REQ:
  - mem_req_valid=1, we=1, addr={victim_tag, beat}, wdata=captured word.
  - Valid, addr and wdata are held stable until mem_req_ready.
  - On handshake: if beat==WORDS_PER_BLOCK-1, set beat=0 and go to FETCH_REQ (if do_fetch) else DONE. Otherwise beat++ and go to WB_RD.
- FETCH_REQ:
  - mem_req_valid=1, we=0, addr={miss_req tag, beat}.
  - Held until mem_req_ready; on handshake go to FETCH_WAIT.
- FETCH_WAIT:
  - On mem_rsp_valid: same cycle refill_we=1, way=victim, word=beat, data=mem_rsp_data.
  - Then at last beat go to DONE, else beat++ and go to FETCH_REQ.
  - mem_rsp_valid outside FETCH_WAIT is ignored.
- DONE: done_valid=1 for one cycle, done_req_id=latched req_id; go to IDLE.

Ordering and counter:
- At most one outstanding memory read.
- Beat counter is OFFSET_WIDTH bits; the transition on the last beat also returns it to 0.

Latency:
- Zero-wait memory, fetch only: 1 + 8×2 + 1 cycles from accept to done.

Decomposition:
- design_params gains ctrl_state_t (enum: IDLE, WB_RD, WB_REQ, FETCH_REQ, FETCH_WAIT, DONE) and mem_req_t (we, addr, wdata).
- Optional sub-module cache_beat_counter holds the beat count and produces a last-beat flag.
- Everything else stays in one module.

Test Plan:
- Clean fetch: miss with do_fetch=1, do_writeback=0, tag=0x1234, victim=4'b0010, ready/rsp immediate → 8 reads at addr 0x91A0..0x91A7, 8 refill_we with word 0..7, way 0010; done_valid with req_id 5.
- Dirty eviction: do_writeback=1, do_fetch=1, victim_tag=0x10, array data word i = 0xA0+i → 8 writes at addr 0x80..0x87 with wdata 0xA0..0xA7, then 8 fetch reads; stall high throughout.
- Backpressure: mem_req_ready low 5 cycles per beat → mem_req_valid/addr/wdata stable while low; exactly one handshake per beat.
- Delayed response: mem_rsp_valid 7 cycles after each request → no second read issued before the response; refill order 0..7.
- No-op entry: do_fetch=0, do_writeback=0 → done_valid 1 cycle after accept; no memory traffic.
- Reset mid-writeback: assert rst_n low at beat 3 → all outputs 0 and miss_ready=1 immediately; no done pulse; next miss starts at beat 0.
